wb_regfile: RTL and testbench

Write-back-side architectural state for the OpenMIPS pipeline: the 32×32 general-purpose register file plus the HI/LO pair.
- Consumes the write-back bundle produced by the MEM/WB pipeline register: register write enable/address/data and HI/LO write enable/values.
- Serves two combinational read ports to the decode stage and the current HI/LO values to the execute stage.
- Same-cycle write-to-read bypass is provided, so write-back data is visible to readers in the cycle it is presented.

---
 rtl/wb_regfile.sv | 84 ++++++++
 tb/tb_wb_regfile.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - OpenMIPS write-back register file (32 GPRs + HI/LO) with same-cycle bypass
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_wreg,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              wb_whilo,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_wreg && (wb_waddr != '0)) begin
            regs[wb_waddr] <= wb_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (wb_whilo) begin
            hi_q <= wb_hi;
            lo_q <= wb_lo;
        end
    end

    // r0 is forced to zero ahead of the bypass so a discarded r0 write never leaks through
    always_comb begin
        rdata1 = '0;
        if (rst || (raddr1 == '0)) begin
            rdata1 = '0;
        end else if (re1 && wb_wreg && (raddr1 == wb_waddr)) begin
            rdata1 = wb_wdata;
        end else if (re1) begin
            rdata1 = regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst || (raddr2 == '0)) begin
            rdata2 = '0;
        end else if (re2 && wb_wreg && (raddr2 == wb_waddr)) begin
            rdata2 = wb_wdata;
        end else if (re2) begin
            rdata2 = regs[raddr2];
        end
    end

    always_comb begin
        hi_o = hi_q;
        lo_o = lo_q;
        if (rst) begin
            hi_o = '0;
            lo_o = '0;
        end else if (wb_whilo) begin
            hi_o = wb_hi;
            lo_o = wb_lo;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed self-checking bench for wb_regfile
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_wreg;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int errors = 0;
    int checks = 0;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .NREG(32)) dut (
        .clk(clk), .rst(rst),
        .wb_wreg(wb_wreg), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        wb_wreg = 1'b0; wb_waddr = '0; wb_wdata = '0;
        wb_whilo = 1'b0; wb_hi = '0; wb_lo = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
    endtask

    // Advance one rising edge and leave time 1 unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        wb_wreg = 1'b1; wb_waddr = a; wb_wdata = d;
        step();
        wb_wreg = 1'b0;
    endtask

    task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
        wb_whilo = 1'b1; wb_hi = h; wb_lo = l;
        step();
        wb_whilo = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #2;
        checks++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: r1=%h r2=%h hi=%h lo=%h required all 0", rdata1, rdata2, hi_o, lo_o);
        end
        step();
        rst = 1'b0;
        step();
        write_reg(5'd5, 32'h1234_5678);
        write_hilo(32'hAAAA_0000, 32'h0000_5555);
        re1 = 1'b1; raddr1 = 5'd5;
        #1;
        checks++;
        if (rdata1 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL reset_preload_r5: got %h required 12345678", rdata1);
        end
        // Pulse reset between edges: the clear must not wait for clk
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (rdata1 !== 32'h0 || hi_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_async: r5=%h hi=%h required 0 0", rdata1, hi_o);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (rdata1 !== 32'h0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_after_release: r5=%h hi=%h lo=%h required 0", rdata1, hi_o, lo_o);
        end
        // A write at an edge with rst high is dropped
        @(negedge clk);
        rst = 1'b1; wb_wreg = 1'b1; wb_waddr = 5'd6; wb_wdata = 32'hBAD0_BAD0;
        step();
        rst = 1'b0; wb_wreg = 1'b0;
        re1 = 1'b1; raddr1 = 5'd6;
        #1;
        checks++;
        if (rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_write_dropped: r6=%h required 0", rdata1);
        end
        idle_inputs();
    endtask

    task automatic test_basic_rw();
        write_reg(5'd7, 32'hDEAD_BEEF);
        re2 = 1'b1; raddr2 = 5'd7;
        #1;
        checks++;
        if (rdata2 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL basic_read_r7: got %h required deadbeef", rdata2);
        end
        re2 = 1'b0;
        #1;
        checks++;
        if (rdata2 !== 32'h0) begin
            errors++;
            $display("FAIL basic_read_disabled: got %h required 0", rdata2);
        end
        write_reg(5'd12, 32'h0C0C_0C0C);
        re1 = 1'b1; raddr1 = 5'd12; re2 = 1'b1; raddr2 = 5'd7;
        #1;
        checks++;
        if (rdata1 !== 32'h0C0C_0C0C || rdata2 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL basic_two_ports: r1=%h r2=%h required 0c0c0c0c deadbeef", rdata1, rdata2);
        end
        idle_inputs();
    endtask

    task automatic test_bypass();
        write_reg(5'd3, 32'h0000_0011);
        @(negedge clk);
        wb_wreg = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h0000_00FF;
        re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd3;
        #1;
        checks++;
        if (rdata1 !== 32'h0000_00FF || rdata2 !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL bypass_same_cycle: r1=%h r2=%h required ff ff", rdata1, rdata2);
        end
        // Bypass applies only when the port is enabled
        re2 = 1'b0;
        #1;
        checks++;
        if (rdata2 !== 32'h0) begin
            errors++;
            $display("FAIL bypass_disabled_port: r2=%h required 0", rdata2);
        end
        re2 = 1'b1;
        step();
        wb_wreg = 1'b0; wb_wdata = 32'h0;
        #1;
        checks++;
        if (rdata1 !== 32'h0000_00FF || rdata2 !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL bypass_stored: r1=%h r2=%h required ff ff", rdata1, rdata2);
        end
        idle_inputs();
    endtask

    task automatic test_r0();
        @(negedge clk);
        wb_wreg = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'hFFFF_FFFF;
        re1 = 1'b1; raddr1 = 5'd0;
        #1;
        checks++;
        if (rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL r0_bypass: got %h required 0", rdata1);
        end
        step();
        wb_wreg = 1'b0;
        #1;
        checks++;
        if (rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL r0_after_write: got %h required 0", rdata1);
        end
        step();
        checks++;
        if (rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL r0_later: got %h required 0", rdata1);
        end
        idle_inputs();
    endtask

    task automatic test_hilo();
        @(negedge clk);
        wb_whilo = 1'b1; wb_hi = 32'h1; wb_lo = 32'h2;
        #1;
        checks++;
        if (hi_o !== 32'h1 || lo_o !== 32'h2) begin
            errors++;
            $display("FAIL hilo_bypass: hi=%h lo=%h required 1 2", hi_o, lo_o);
        end
        step();
        wb_whilo = 1'b0; wb_hi = 32'h9; wb_lo = 32'h8;
        #1;
        checks++;
        if (hi_o !== 32'h1 || lo_o !== 32'h2) begin
            errors++;
            $display("FAIL hilo_held: hi=%h lo=%h required 1 2", hi_o, lo_o);
        end
        step();
        checks++;
        if (hi_o !== 32'h1 || lo_o !== 32'h2) begin
            errors++;
            $display("FAIL hilo_no_write: hi=%h lo=%h required 1 2", hi_o, lo_o);
        end
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        wb_wreg = 1'b1; wb_waddr = 5'd31; wb_wdata = 32'h5;
        wb_whilo = 1'b1; wb_hi = 32'h6; wb_lo = 32'h7;
        step();
        wb_wreg = 1'b0; wb_whilo = 1'b0; wb_hi = 32'h0; wb_lo = 32'h0;
        re1 = 1'b1; raddr1 = 5'd31;
        #1;
        checks++;
        if (rdata1 !== 32'h5 || hi_o !== 32'h6 || lo_o !== 32'h7) begin
            errors++;
            $display("FAIL simul_update: r31=%h hi=%h lo=%h required 5 6 7", rdata1, hi_o, lo_o);
        end
        wb_waddr = 5'd31; wb_wdata = 32'h9;
        #1;
        checks++;
        if (rdata1 !== 32'h5) begin
            errors++;
            $display("FAIL bubble_no_bypass: r31=%h required 5", rdata1);
        end
        step();
        checks++;
        if (rdata1 !== 32'h5) begin
            errors++;
            $display("FAIL bubble_no_write: r31=%h required 5", rdata1);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i < 32; i++) begin
            wb_wreg = 1'b1; wb_waddr = 5'(i); wb_wdata = 32'hA500_0000 | 32'(i);
            step();
        end
        wb_wreg = 1'b0;
        re1 = 1'b1; re2 = 1'b1;
        for (int i = 1; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(32 - i);
            #1;
            checks++;
            if (rdata1 !== (32'hA500_0000 | 32'(i)) || rdata2 !== (32'hA500_0000 | 32'(32 - i))) begin
                errors++;
                $display("FAIL b2b_read_%0d: r1=%h r2=%h required %h %h", i, rdata1, rdata2,
                         32'hA500_0000 | 32'(i), 32'hA500_0000 | 32'(32 - i));
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic_rw();
        test_bypass();
        test_r0();
        test_hilo();
        test_simultaneous();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
